// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the data-RAM bus arbiter.
package mem_bus_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_HANDOVER = 2'd2
  } arb_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side request/strobe bus plus the RAM-side port, grouped for the arbiter.
interface mem_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = mem_bus_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W      = mem_bus_pkg::DEF_DATA_W
);
  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS-1:0]        m_gnt;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]        m_write;
  logic [NUM_MASTERS-1:0]        m_read;
  logic [DATA_W-1:0]             m_rdata;
  logic [NUM_MASTERS-1:0]        m_rvalid;
  logic [ADDR_W-1:0]             mem_addr;
  logic [DATA_W-1:0]             mem_din;
  logic                          mem_write;
  logic                          mem_read;
  logic [DATA_W-1:0]             mem_dout;

  modport slave (
    input  m_req, m_addr, m_wdata, m_write, m_read, mem_dout,
    output m_gnt, m_rdata, m_rvalid, mem_addr, mem_din, mem_write, mem_read
  );

  modport master (
    output m_req, m_addr, m_wdata, m_write, m_read, mem_dout,
    input  m_gnt, m_rdata, m_rvalid, mem_addr, mem_din, mem_write, mem_read
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester after i_last, wrapping.
module rr_pick #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_last,
  output logic                   o_found,
  output logic [IDX_W-1:0]       o_idx
);

  int unsigned w_cand;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      w_cand = (32'(i_last) + k) % NUM_MASTERS;
      if (!o_found && i_req[IDX_W'(w_cand)]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master round-robin arbiter for the single-port data RAM with tagged read return.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 2,
  parameter  int unsigned ADDR_W      = DEF_ADDR_W,
  parameter  int unsigned DATA_W      = DEF_DATA_W,
  parameter  int unsigned RD_LAT      = 1,
  parameter  int unsigned MAX_HOLD    = 0,
  localparam int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  mem_bus_arbiter_if.slave io_bus,
  output logic [IDX_W-1:0] o_owner,
  output logic             o_busy
);

  localparam int unsigned HOLD_W    = idx_width(MAX_HOLD);
  localparam int unsigned HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_e             r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]       r_owner, w_owner_nxt;
  logic [IDX_W-1:0]       r_rr_last, w_rr_nxt;
  logic                   r_busy, w_busy_nxt;
  logic [HOLD_W-1:0]      r_hold, w_hold_nxt;
  logic [ADDR_W-1:0]      r_addr_q;
  logic [DATA_W-1:0]      r_din_q;
  logic [RD_LAT-1:0]      r_pipe_vld;
  logic [IDX_W-1:0]       r_pipe_tag [RD_LAT];

  logic              w_found;
  logic [IDX_W-1:0]  w_pick;
  logic              w_in_grant, w_own_req, w_own_wr, w_own_rd, w_others, w_preempt;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_wdata;
  logic              w_mem_read;

  rr_pick #(.NUM_MASTERS(NUM_MASTERS), .IDX_W(IDX_W)) u_rr_pick (
    .i_req   (io_bus.m_req),
    .i_last  (r_rr_last),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_in_grant  = (r_state == ST_GRANT);
  assign w_own_req   = io_bus.m_req[r_owner];
  assign w_own_wr    = io_bus.m_write[r_owner];
  assign w_own_rd    = io_bus.m_read[r_owner];
  assign w_own_addr  = io_bus.m_addr[32'(r_owner)*ADDR_W +: ADDR_W];
  assign w_own_wdata = io_bus.m_wdata[32'(r_owner)*DATA_W +: DATA_W];
  assign w_others    = |(io_bus.m_req & ~r_gnt);
  assign w_preempt   = (MAX_HOLD != 0) && (r_hold == HOLD_W'(HOLD_LAST)) && w_others;

  // Only the owner reaches the RAM; a simultaneous write beats the read.
  assign w_mem_read       = w_in_grant & w_own_rd & ~w_own_wr;
  assign io_bus.mem_read  = w_mem_read;
  assign io_bus.mem_write = w_in_grant & w_own_wr;
  assign io_bus.mem_addr  = w_in_grant ? w_own_addr : r_addr_q;
  assign io_bus.mem_din   = w_in_grant ? w_own_wdata : r_din_q;

  assign io_bus.m_gnt    = r_gnt;
  assign io_bus.m_rvalid = r_pipe_vld[RD_LAT-1] ? (NUM_MASTERS'(1) << r_pipe_tag[RD_LAT-1]) : '0;
  assign io_bus.m_rdata  = r_pipe_vld[RD_LAT-1] ? io_bus.mem_dout : '0;
  assign o_owner         = r_owner;
  assign o_busy          = r_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_rr_last <= IDX_W'(NUM_MASTERS - 1);
      r_busy    <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_last <= w_rr_nxt;
      r_busy    <= w_busy_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_last;
    w_busy_nxt  = r_busy;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      ST_IDLE, ST_HANDOVER: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = NUM_MASTERS'(1) << w_pick;
          w_owner_nxt = w_pick;
          w_rr_nxt    = w_pick;
          w_busy_nxt  = 1'b1;
          w_hold_nxt  = '0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!w_own_req || w_preempt) begin
          w_state_nxt = ST_HANDOVER;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end else if (r_hold != HOLD_W'(HOLD_LAST)) begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Last granted address/data stay on the RAM pins between grants.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr_q <= '0;
      r_din_q  <= '0;
    end else if (w_in_grant) begin
      r_addr_q <= w_own_addr;
      r_din_q  <= w_own_wdata;
    end
  end

  // Read tags travel alongside the RAM latency so grant changes cannot misroute data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe_vld <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) r_pipe_tag[i] <= '0;
    end else begin
      r_pipe_vld[0] <= w_mem_read;
      r_pipe_tag[0] <= r_owner;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: a 2-master/latency-1 arbiter driven from a vector table, and a
// 3-master/latency-3/hold-4 arbiter exercised by hand-written sequences.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst_n;
  logic       owner_a;
  logic       busy_a;
  logic [1:0] owner_b;
  logic       busy_b;

  mem_bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(16), .DATA_W(8)) bus_a ();
  mem_bus_arbiter_if #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(8)) bus_b ();

  mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(16), .DATA_W(8), .RD_LAT(1), .MAX_HOLD(0)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus_a),
    .o_owner (owner_a),
    .o_busy  (busy_a)
  );

  mem_bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(8), .RD_LAT(3), .MAX_HOLD(4)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus_b),
    .o_owner (owner_b),
    .o_busy  (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM models: latency 1 for A, latency 3 for B; preloaded during reset.
  logic [7:0] ram_a [65536];
  logic [7:0] ram_b [65536];
  logic [7:0] rb_d1, rb_d2;

  always @(posedge clk) begin
    if (!rst_n) begin
      ram_a[16'h0040] <= 8'h11;
    end else begin
      if (bus_a.mem_write) ram_a[bus_a.mem_addr] <= bus_a.mem_din;
      if (bus_a.mem_read)  bus_a.mem_dout <= ram_a[bus_a.mem_addr];
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      ram_b[16'h0100] <= 8'hC3;
    end else begin
      if (bus_b.mem_write) ram_b[bus_b.mem_addr] <= bus_b.mem_din;
      rb_d1          <= ram_b[bus_b.mem_addr];
      rb_d2          <= rb_d1;
      bus_b.mem_dout <= rb_d2;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req, wr, rd;
    logic [15:0] a0, a1;
    logic [7:0]  d0, d1;
    logic [1:0]  gnt;
    logic        own, busy, mw, mr;
    logic [15:0] maddr;
    logic [7:0]  mdin;
    logic [1:0]  rv;
    logic [7:0]  rdat;
  } vec_t;

  vec_t       vecs [16];
  logic [2:0] exp_gnt_b [17];

  initial begin
    vecs[0]  = '{2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 2'b00, 8'h00};
    vecs[1]  = '{2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 2'b00, 8'h00};
    vecs[2]  = '{2'b11, 2'b11, 2'b00, 16'h0030, 16'h0040, 8'h3C, 8'h77, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0030, 8'h3C, 2'b00, 8'h00};
    vecs[3]  = '{2'b10, 2'b10, 2'b00, 16'h0030, 16'h0040, 8'h3C, 8'h77, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 8'h3C, 2'b00, 8'h00};
    vecs[4]  = '{2'b10, 2'b10, 2'b00, 16'h0000, 16'h0040, 8'h00, 8'h77, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 8'h3C, 2'b00, 8'h00};
    vecs[5]  = '{2'b10, 2'b00, 2'b10, 16'h0000, 16'h0040, 8'h00, 8'h00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 8'h00, 2'b00, 8'h00};
    vecs[6]  = '{2'b11, 2'b10, 2'b00, 16'h0000, 16'h0010, 8'h00, 8'hA5, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 8'hA5, 2'b10, 8'h11};
    vecs[7]  = '{2'b11, 2'b00, 2'b10, 16'h0000, 16'h0010, 8'h00, 8'h00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 8'h00, 2'b00, 8'h00};
    vecs[8]  = '{2'b11, 2'b10, 2'b10, 16'h0000, 16'h0050, 8'h00, 8'h5A, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0050, 8'h5A, 2'b10, 8'hA5};
    vecs[9]  = '{2'b01, 2'b00, 2'b00, 16'h0000, 16'h0050, 8'h00, 8'h5A, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0050, 8'h5A, 2'b00, 8'h00};
    vecs[10] = '{2'b01, 2'b00, 2'b00, 16'h0055, 16'h0099, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0050, 8'h5A, 2'b00, 8'h00};
    vecs[11] = '{2'b01, 2'b00, 2'b01, 16'h0050, 16'h0000, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0050, 8'h00, 2'b00, 8'h00};
    vecs[12] = '{2'b00, 2'b00, 2'b00, 16'h0050, 16'h0000, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050, 8'h00, 2'b01, 8'h5A};
    vecs[13] = '{2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050, 8'h00, 2'b00, 8'h00};
    vecs[14] = '{2'b10, 2'b00, 2'b00, 16'h0000, 16'h0010, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0050, 8'h00, 2'b00, 8'h00};
    vecs[15] = '{2'b10, 2'b00, 2'b00, 16'h0000, 16'h0010, 8'h00, 8'h00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00, 2'b00, 8'h00};

    exp_gnt_b = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                  3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
                  3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};

    rst_n         = 1'b0;
    bus_a.m_req   = '0;
    bus_a.m_write = '0;
    bus_a.m_read  = '0;
    bus_a.m_addr  = '0;
    bus_a.m_wdata = '0;
    bus_b.m_req   = '0;
    bus_b.m_write = '0;
    bus_b.m_read  = '0;
    bus_b.m_addr  = '0;
    bus_b.m_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven: inputs applied in a cycle, outputs sampled in that same cycle.
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      bus_a.m_req   = vecs[v].req;
      bus_a.m_write = vecs[v].wr;
      bus_a.m_read  = vecs[v].rd;
      bus_a.m_addr  = {vecs[v].a1, vecs[v].a0};
      bus_a.m_wdata = {vecs[v].d1, vecs[v].d0};
      #1;
      chk($sformatf("a_gnt_v%0d", v),   32'(bus_a.m_gnt),     32'(vecs[v].gnt));
      chk($sformatf("a_owner_v%0d", v), 32'(owner_a),         32'(vecs[v].own));
      chk($sformatf("a_busy_v%0d", v),  32'(busy_a),          32'(vecs[v].busy));
      chk($sformatf("a_mwr_v%0d", v),   32'(bus_a.mem_write), 32'(vecs[v].mw));
      chk($sformatf("a_mrd_v%0d", v),   32'(bus_a.mem_read),  32'(vecs[v].mr));
      chk($sformatf("a_maddr_v%0d", v), 32'(bus_a.mem_addr),  32'(vecs[v].maddr));
      chk($sformatf("a_mdin_v%0d", v),  32'(bus_a.mem_din),   32'(vecs[v].mdin));
      chk($sformatf("a_rvld_v%0d", v),  32'(bus_a.m_rvalid),  32'(vecs[v].rv));
      chk($sformatf("a_rdat_v%0d", v),  32'(bus_a.m_rdata),   32'(vecs[v].rdat));
    end

    // Preemption after 4 grant cycles, rotation 1,2,0, and a read returning after handover.
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      bus_b.m_req  = (c == 0) ? 3'b001 : 3'b111;
      bus_b.m_read = (c == 4) ? 3'b001 : 3'b000;
      bus_b.m_addr = {16'h0000, 16'h0000, 16'h0100};
      #1;
      chk($sformatf("b_gnt_c%0d", c),  32'(bus_b.m_gnt),    32'(exp_gnt_b[c]));
      chk($sformatf("b_rvld_c%0d", c), 32'(bus_b.m_rvalid), (c == 7) ? 32'h1 : 32'h0);
      if (c == 4) chk("b_mrd_last_grant", 32'(bus_b.mem_read), 32'h1);
      if (c == 7) begin
        chk("b_rdat_late", 32'(bus_b.m_rdata), 32'hC3);
        chk("b_owner_late", 32'(owner_b), 32'h1);
      end
    end
    @(negedge clk);
    bus_b.m_req  = '0;
    bus_b.m_read = '0;

    // Asynchronous reset while a read is in flight.
    @(negedge clk);
    bus_a.m_req   = 2'b10;
    bus_a.m_write = 2'b00;
    bus_a.m_read  = 2'b10;
    bus_a.m_addr  = {16'h0010, 16'h0000};
    #1;
    chk("r_pre_gnt", 32'(bus_a.m_gnt), 32'h2);
    chk("r_pre_mrd", 32'(bus_a.mem_read), 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_gnt",   32'(bus_a.m_gnt),    32'h0);
    chk("r_busy",  32'(busy_a),         32'h0);
    chk("r_owner", 32'(owner_a),        32'h0);
    chk("r_rvld",  32'(bus_a.m_rvalid), 32'h0);
    chk("r_rdat",  32'(bus_a.m_rdata),  32'h0);
    chk("r_mrd",   32'(bus_a.mem_read), 32'h0);
    @(negedge clk);
    bus_a.m_req  = '0;
    bus_a.m_read = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("r_post_rvld%0d", k), 32'(bus_a.m_rvalid), 32'h0);
      chk($sformatf("r_post_busy%0d", k), 32'(busy_a), 32'h0);
    end
    @(negedge clk);
    bus_a.m_req = 2'b11;
    #1;
    chk("r_req_lat", 32'(bus_a.m_gnt), 32'h0);
    @(negedge clk);
    #1;
    chk("r_first_gnt", 32'(bus_a.m_gnt), 32'h1);
    chk("r_first_own", 32'(owner_a), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- N-master arbiter for the single-port data RAM.
- Generalises the fixed IO/CPU select muxing to NUM_MASTERS requesters, e.g. IO/UART loader, processor, and a future DMA or second core.
- Each master raises a request and is granted exclusive ownership of the RAM address/data/strobe bus. Arbitration is round-robin, with an optional hold limit for fairness.
- Read data is routed back to the master that issued the read, tagged through a latency pipeline, so a grant change never misroutes data.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in clk cycles, from mem_read to valid mem_dout (1..4).
- MAX_HOLD, 0, maximum consecutive GRANT cycles while another master is requesting; 0 = unlimited.
- IDX_W, $clog2(NUM_MASTERS) (min 1), width of owner index.

Ports:
- clk  in  1  system clock (the generated RAM clock domain)
- reset  in  1  asynchronous, active-low reset (0 = reset)
- m_req  in  NUM_MASTERS  per-master bus request, level held while ownership is wanted
- m_gnt  out  NUM_MASTERS  one-hot grant, registered
- m_addr  in  NUM_MASTERS*ADDR_W  packed per-master addresses; master i occupies [i*ADDR_W +: ADDR_W]
- m_wdata  in  NUM_MASTERS*DATA_W  packed per-master write data
- m_write  in  NUM_MASTERS  per-master write strobe
- m_read  in  NUM_MASTERS  per-master read strobe
- m_rdata  out  DATA_W  read data, broadcast to all masters
- m_rvalid  out  NUM_MASTERS  one-hot; m_rdata is valid for master i
- mem_addr  out  ADDR_W  to RAM addr
- mem_din  out  DATA_W  to RAM din
- mem_write  out  1  to RAM write
- mem_read  out  1  to RAM read
- mem_dout  in  DATA_W  from RAM dout
- owner  out  IDX_W  index of the current or last owner
- busy  out  1  high in GRANT or HANDOVER

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; m_gnt=0; owner=0; busy=0; mem_read=mem_write=0; m_rvalid=0; m_rdata=0.
  - Read pipeline cleared; hold counter=0.
  - RR pointer set so master 0 has highest priority.
  - Reset mid-transfer discards in-flight reads; no rvalid is produced for them.
- FSM states IDLE, GRANT, HANDOVER:
  - IDLE: if |m_req, pick the first requester scanning from (last owner+1) mod N. Next cycle: state=GRANT, m_gnt one-hot, owner updated. Latency from req to gnt = 1 cycle.
  - GRANT: mem_addr/mem_din/mem_write/mem_read are driven combinationally from the owner's inputs. Leave GRANT when either:
    - the owner drops m_req, or
    - MAX_HOLD != 0, the hold counter = MAX_HOLD-1, and another master is requesting (preemption).
  - HANDOVER: exactly 1 cycle with m_gnt=0 and mem strobes=0. Then pick the next RR winner into GRANT, or go to IDLE if none is requesting.
- Strobes from non-granted masters are ignored: no RAM access, no error.
- Owner asserting m_write and m_read in the same cycle: write wins, read suppressed, no rvalid.
- Outside GRANT: mem_addr/mem_din hold their last values; strobes are 0.
- Hold counter:
  - Counts GRANT cycles; resets on entry to GRANT.
  - Saturates if no competitor is requesting.
  - Ignored when MAX_HOLD=0.
- Read return:
  - Each issued mem_read pushes {valid=1, owner} into an RD_LAT-deep shift register.
  - At the output stage, m_rvalid[tag]=1 and m_rdata=mem_dout, exactly RD_LAT cycles after the mem_read cycle.
  - Delivery is independent of later grant changes or HANDOVER.
  - Back-to-back reads sustain 1 per cycle.
- A preempted master sees m_gnt fall. It must keep m_req high to be re-queued; it gets the lowest priority in the next round.

Decomposition:
- Shared package (mem_bus_pkg): state encoding localparams (IDLE/GRANT/HANDOVER) and default width constants ADDR_W=16, DATA_W=8.
- One natural sub-module: rr_pick, a combinational round-robin selector. Inputs are the req vector and the last owner; outputs are a found flag and the winner index. It is reused by both the IDLE and HANDOVER transitions.

Test Plan:
- N=2, RD_LAT=1, MAX_HOLD=0. Master 1 req from IDLE -> m_gnt=2'b10 next cycle. Master 1 writes 0xA5 @0x0010, then reads @0x0010 -> m_rvalid=2'b10 with m_rdata=0xA5 one cycle after mem_read.
- Both masters req simultaneously from reset -> master 0 granted first. Master 0 drops req -> 1 HANDOVER cycle with gnt=0, strobes=0, then gnt=2'b10. A repeat of the sequence grants master 0 second only after master 1 releases.
- N=3, MAX_HOLD=4. Master 0 holds req and masters 1 and 2 request -> master 0 loses gnt after 4 GRANT cycles; grants follow the order 1, 2, 0.
- RD_LAT=3. Owner 0 issues reads on its last GRANT cycle, then handover to master 1 -> m_rvalid[0] asserts 3 cycles after that read, carrying the correct data, while master 1 is owner. m_rvalid[1] is never falsely set.
- Non-owner master 1 pulses m_write while master 0 owns the bus -> mem_write follows master 0 only; RAM content at master 1's address is unchanged.
- reset=0 asserted asynchronously mid-GRANT with a read in flight -> outputs are immediately 0 and no rvalid appears after release. First request after reset is granted per RR from master 0.
